weight_buffer_pp: RTL
=====================

# weight_buffer_pp

Double-buffered twiddle-weight store for the full-parallel FFT datapath. A serial real/imaginary weight stream is loaded into a shadow bank under a valid/ready handshake. An explicit commit copies the shadow bank into the active bank, which drives the butterfly array in parallel. Reloading therefore never disturbs the weights in use; the block adds fill counting, backpressure, abort and commit-error reporting.

## Interface
- NPOINT, 3, log2 of FFT size; NWORD = NPOINT * 2**(NPOINT-1) weight words per set
- WIDTH, 16, bits per real or imaginary weight component
- CW, derived, $clog2(NWORD+1), width of load_count
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  asynchronous reset, active low
- din_weight_valid  in  1  input word valid
- din_weight_ready  out  1  block accepts a word this cycle
- din_weight_real  in  WIDTH  real part of input word
- din_weight_imag  in  WIDTH  imaginary part of input word
- load_clear  in  1  abort the current shadow load
- commit  in  1  request shadow-to-active swap
- load_count  out  CW  words held in the shadow bank
- load_full  out  1  shadow bank holds NWORD words
- commit_err  out  1  one-cycle pulse: commit rejected
- weight_valid  out  1  active bank holds a committed set
- weight_real  out  NWORD*WIDTH  active real weights, parallel
- weight_imag  out  NWORD*WIDTH  active imaginary weights, parallel

## Operation
- States:
  - S_IDLE: reset state only.
  - S_LOAD: accepting words.
  - S_FULL: shadow complete, awaiting commit.
- S_IDLE goes to S_LOAD unconditionally on the first edge after reset release.
- din_weight_ready = (state == S_LOAD), decoded from the state register only. It is 0 in S_IDLE and S_FULL.
- Accept = valid && ready. On accept:
  - The shadow bank shifts up by WIDTH; the new word enters bits [WIDTH-1:0].
  - load_count increments.
  - After NWORD accepts, the first word sits in slot NWORD-1 (top bits) and the last word in slot 0.
- The accept that raises load_count to NWORD moves the state to S_FULL. load_full = (state == S_FULL).
- Commit in S_FULL:
  - The active bank is loaded from the shadow bank.
  - weight_valid is set to 1.
  - load_count returns to 0 and the state returns to S_LOAD.
- Commit in S_LOAD or S_IDLE: no state change; commit_err pulses high for exactly one cycle.
- load_clear, in any state other than S_IDLE:
  - load_count returns to 0 and the state returns to S_LOAD.
  - Shadow contents are not cleared; they are don't-care until overwritten.
  - The active bank and weight_valid are unaffected.
- Priority within one cycle: load_clear > commit > accept.
  - load_clear together with commit: the commit is dropped with no commit_err.
  - load_clear together with an accept: the word is discarded and load_count becomes 0.
- The active bank changes only on a successful commit. Outputs are registered and glitch-free between commits.
- A partial reload followed by load_clear leaves the previous committed set intact on the outputs.

## Timing
- Reset values:
  - state = S_IDLE; din_weight_ready = 0.
  - load_count = 0; load_full = 0; commit_err = 0.
  - weight_valid = 0; weight_real and weight_imag = 0; shadow bank = 0.
- Ready asserts 1 cycle after rst_n deasserts (first edge).
- Accept throughput: 1 word/cycle. Minimum full load is NWORD cycles.
- load_full asserts on the edge of the NWORD-th accept. Ready drops in the same cycle it is seen high.
- Commit latency: weight_* and weight_valid update on the edge that samples commit. Ready is 1 in the following cycle.
- Back-to-back reloads: commit at cycle t, first new word accepted at t+1. Weights stay stable from t+1 until the next commit.
- commit_err is registered: high the cycle after the rejected commit edge, low the cycle after.
- Reset mid-load or mid-commit clears everything, including the active bank, per the reset values above.

## Structure
- Shared package/header holds:
  - The state encoding (S_IDLE/S_LOAD/S_FULL, 2 bits).
  - The NWORD and CW derivation, reused by the FFT top and the weight ROM loader.
- One sub-module, weight_shift_bank: a parametrised WIDTH x NWORD shift register with enable and parallel output, instanced twice (real and imaginary shadow).
- Control FSM, counter and active registers live in the top module.

## Test plan
All scenarios use NPOINT = 3, WIDTH = 16, so NWORD = 12.
- **Reset:** after release, ready is 0 then 1 after one edge; all outputs are 0 and weight_valid is 0.
- **Full load and commit:**
  - Stimulus: 12 accepted words, real = 1..12 and imag = 0x100+k, then commit.
  - Response: weight_real[191:176] = 1 and [15:0] = 12; weight_valid = 1; load_count returns to 0.
- **Backpressure:** hold valid high for 14 cycles. Exactly 12 words are accepted; ready is 0 and load_full is 1 from the 13th cycle until commit.
- **Early commit:** commit after 5 words. commit_err pulses once, load_count stays 5, and the outputs are unchanged.
- **Clear mid-reload:**
  - Stimulus: after a committed set A, load 7 words, assert load_clear, then load a full set B and commit.
  - Response: outputs show set A until the commit, then exactly set B.
- **Priority:** load_clear + commit in S_FULL gives no swap, no commit_err, and load_count 0. load_clear + accept leaves load_count at 0.

Source files
------------

// File: rtl/weight_buffer_pp_pkg.sv
// Shared definitions for the double-buffered FFT twiddle-weight store:
// state encoding plus the weight-set size and counter-width derivations.
package weight_buffer_pp_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_FULL = 2'd2
    } wb_state_e;

    // Weight words per set for an FFT of size 2**npoint.
    function automatic int nword_f(input int npoint);
        return npoint * (32'sd1 <<< (npoint - 32'sd1));
    endfunction

    // Counter width able to hold 0..nword inclusive.
    function automatic int cw_f(input int nword);
        return $clog2(nword + 32'sd1);
    endfunction

endpackage

// File: rtl/weight_buffer_pp_shift_bank.sv
// Shadow store: a DEPTH-slot shift register of WIDTH-bit words. New words
// enter slot 0, so the oldest word ends up in the top slot.
module weight_shift_bank #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 12
)(
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     shift_en_i,
    input  logic [WIDTH-1:0]         din_i,
    output logic [DEPTH*WIDTH-1:0]   bank_o
);

    logic [DEPTH*WIDTH-1:0] bank_q;

    // Shift one slot up on each enabled cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bank_q <= '0;
        end else if (shift_en_i) begin
            bank_q <= {bank_q[DEPTH*WIDTH-WIDTH-1:0], din_i};
        end else begin
            bank_q <= bank_q;
        end
    end

    assign bank_o = bank_q;

endmodule

// File: rtl/weight_buffer_pp.sv
// Double-buffered twiddle-weight store: serial load into a shadow bank,
// explicit commit copies it into the parallel active bank.
module weight_buffer_pp
    import weight_buffer_pp_pkg::*;
#(
    parameter  int NPOINT = 3,
    parameter  int WIDTH  = 16,
    localparam int NWORD  = nword_f(NPOINT),
    localparam int CW     = cw_f(NWORD)
)(
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     din_weight_valid,
    output logic                     din_weight_ready,
    input  logic [WIDTH-1:0]         din_weight_real,
    input  logic [WIDTH-1:0]         din_weight_imag,
    input  logic                     load_clear,
    input  logic                     commit,
    output logic [CW-1:0]            load_count,
    output logic                     load_full,
    output logic                     commit_err,
    output logic                     weight_valid,
    output logic [NWORD*WIDTH-1:0]   weight_real,
    output logic [NWORD*WIDTH-1:0]   weight_imag
);

    wb_state_e                state_q, state_d;
    logic [CW-1:0]            count_q, count_d;
    logic                     err_q, err_d;
    logic                     valid_q;
    logic [NWORD*WIDTH-1:0]   active_real_q, active_imag_q;
    logic [NWORD*WIDTH-1:0]   shadow_real_s, shadow_imag_s;
    logic                     ready_s;
    logic                     accept_s;
    logic                     shift_en_s;
    logic                     commit_ok_s;

    assign ready_s  = (state_q == S_LOAD);
    assign accept_s = din_weight_valid && ready_s;

    // Next-state decode; priority is load_clear, then commit, then accept.
    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        err_d       = 1'b0;
        shift_en_s  = 1'b0;
        commit_ok_s = 1'b0;
        case (state_q)
            S_IDLE: begin
                state_d = S_LOAD;
                err_d   = commit;
            end
            S_LOAD: begin
                if (load_clear) begin
                    count_d = '0;
                end else if (commit) begin
                    err_d = 1'b1;
                end else if (accept_s) begin
                    shift_en_s = 1'b1;
                    count_d    = count_q + CW'(1);
                    if (count_q == CW'(NWORD - 1)) begin
                        state_d = S_FULL;
                    end else begin
                        state_d = S_LOAD;
                    end
                end else begin
                    count_d = count_q;
                end
            end
            S_FULL: begin
                if (load_clear) begin
                    count_d = '0;
                    state_d = S_LOAD;
                end else if (commit) begin
                    commit_ok_s = 1'b1;
                    count_d     = '0;
                    state_d     = S_LOAD;
                end else begin
                    state_d = S_FULL;
                end
            end
            default: begin
                state_d = S_IDLE;
                count_d = '0;
            end
        endcase
    end

    // Control state, fill counter and the registered error pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            count_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            err_q   <= err_d;
        end
    end

    // Active bank only moves on an accepted commit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active_real_q <= '0;
            active_imag_q <= '0;
            valid_q       <= 1'b0;
        end else if (commit_ok_s) begin
            active_real_q <= shadow_real_s;
            active_imag_q <= shadow_imag_s;
            valid_q       <= 1'b1;
        end else begin
            active_real_q <= active_real_q;
            active_imag_q <= active_imag_q;
            valid_q       <= valid_q;
        end
    end

    weight_shift_bank #(
        .WIDTH (WIDTH),
        .DEPTH (NWORD)
    ) u_shadow_real (
        .clk        (clk),
        .rst_n      (rst_n),
        .shift_en_i (shift_en_s),
        .din_i      (din_weight_real),
        .bank_o     (shadow_real_s)
    );

    weight_shift_bank #(
        .WIDTH (WIDTH),
        .DEPTH (NWORD)
    ) u_shadow_imag (
        .clk        (clk),
        .rst_n      (rst_n),
        .shift_en_i (shift_en_s),
        .din_i      (din_weight_imag),
        .bank_o     (shadow_imag_s)
    );

    assign din_weight_ready = ready_s;
    assign load_full        = (state_q == S_FULL);
    assign load_count       = count_q;
    assign commit_err       = err_q;
    assign weight_valid     = valid_q;
    assign weight_real      = active_real_q;
    assign weight_imag      = active_imag_q;

endmodule
